// File: rtl/s38584_bist_pkg.sv
// Shared types and constants for the s38584 g31793 cone self-test wrapper.
// Optional build macro used by the top: S38584_BIST_RESP_PIPE_EN.
package s38584_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Signature register
  localparam int unsigned SISR_W    = 16;
  localparam logic [15:0] SISR_POLY = 16'h1021;
  localparam logic [15:0] SISR_INIT = 16'hFFFF;

  // Pattern generator: x^11 + x^9 + 1
  localparam int unsigned LFSR_W      = 11;
  localparam int unsigned LFSR_TAP_HI = 10;
  localparam int unsigned LFSR_TAP_LO = 8;

  // Pattern counter, wide enough for the full legal pattern range plus drain
  localparam int unsigned CNT_W = 11;

  // pat_out bit positions for the cone inputs
  localparam int unsigned PAT_G35   = 0;
  localparam int unsigned PAT_G5471 = 1;
  localparam int unsigned PAT_G5817 = 2;
  localparam int unsigned PAT_G5124 = 3;
  localparam int unsigned PAT_G6163 = 4;
  localparam int unsigned PAT_G3817 = 5;
  localparam int unsigned PAT_G3115 = 6;
  localparam int unsigned PAT_G6509 = 7;
  localparam int unsigned PAT_G3466 = 8;
  localparam int unsigned PAT_G4427 = 9;
  localparam int unsigned PAT_G4420 = 10;

  // One Fibonacci LFSR step
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

  // An all-zero seed would lock the LFSR, so substitute 1
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/bist_sisr16.sv
// 16-bit serial-input signature register (CRC-CCITT polynomial).
module bist_sisr16
  import s38584_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  input  logic              din,
  output logic [SISR_W-1:0] sig
);

  logic fb;

  assign fb = sig[SISR_W-1] ^ din;

  // Reset clears, init seeds, enable absorbs one response bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (init) begin
      sig <= SISR_INIT;
    end else if (en) begin
      sig <= {sig[SISR_W-2:0], 1'b0} ^ (fb ? SISR_POLY : '0);
    end
  end

endmodule

// File: rtl/s38584_g31793_bist.sv
// BIST controller for the s38584 g31793 cone: LFSR pattern source, SISR sink,
// pattern counter and run FSM. Optional macro S38584_BIST_RESP_PIPE_EN
// registers cut_resp once before the SISR and adds one drain cycle to RUN.
module s38584_g31793_bist
  import s38584_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 1024,
  parameter logic [10:0] LFSR_SEED    = 11'h001,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  output logic [10:0] pat_out,
  input  logic        cut_resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  // Counter value of the final pattern cycle
  localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(NUM_PATTERNS - 1);
`ifdef S38584_BIST_RESP_PIPE_EN
  // One extra cycle drains the response register
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(NUM_PATTERNS);
`else
  localparam logic [CNT_W-1:0] RUN_LAST = LAST_PAT;
`endif

  state_t            state;
  state_t            state_nx;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  cnt;
  logic              run_last;
  logic              sisr_init;
  logic              sisr_en;
  logic              sisr_din;

`ifdef S38584_BIST_RESP_PIPE_EN
  logic resp_q;

  // Response pipeline stage ahead of the SISR
  always_ff @(posedge CK) begin
    if (RST) resp_q <= 1'b0;
    else     resp_q <= cut_resp;
  end
`endif

  assign run_last = (state == ST_RUN) && (cnt == RUN_LAST);

  // State register
  always_ff @(posedge CK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and SISR control; abort overrides every transition
  always_comb begin
    state_nx  = state;
    sisr_init = 1'b0;
    sisr_en   = 1'b0;
    sisr_din  = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        state_nx  = ST_RUN;
        sisr_init = 1'b1;
      end
      ST_RUN: begin
        if (run_last) state_nx = ST_COMPARE;
`ifdef S38584_BIST_RESP_PIPE_EN
        sisr_en  = (cnt != '0);
        sisr_din = resp_q;
`else
        sisr_en  = 1'b1;
        sisr_din = cut_resp;
`endif
      end
      ST_COMPARE: state_nx = ST_DONE;
      ST_DONE:    if (start) state_nx = ST_LOAD;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort) begin
      state_nx  = ST_IDLE;
      sisr_init = 1'b0;
      sisr_en   = 1'b0;
    end
  end

  // Pattern generator, counter and registered status outputs
  always_ff @(posedge CK) begin
    if (RST) begin
      lfsr    <= '0;
      cnt     <= '0;
      pat_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      busy <= (state_nx == ST_LOAD) || (state_nx == ST_RUN) || (state_nx == ST_COMPARE);
      done <= (state_nx == ST_DONE);
      if (abort) begin
        pat_out <= '0;
        pass    <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            lfsr    <= seed_fix(LFSR_SEED);
            pat_out <= seed_fix(LFSR_SEED);
            cnt     <= '0;
            pass    <= 1'b0;
          end
          ST_RUN: begin
            lfsr <= lfsr_next(lfsr);
            if (!run_last) cnt <= cnt + CNT_W'(1);
            pat_out <= (cnt >= LAST_PAT) ? '0 : lfsr_next(lfsr);
          end
          ST_COMPARE: begin
            pass    <= (signature == GOLDEN_SIG);
            pat_out <= '0;
          end
          default: pat_out <= '0;
        endcase
      end
    end
  end

  bist_sisr16 u_sisr (
    .clk  (CK),
    .rst  (RST),
    .init (sisr_init),
    .en   (sisr_en),
    .din  (sisr_din),
    .sig  (signature)
  );

endmodule
